// File: rtl/reg_file.sv
// Architectural register file with per-register ROB rename aliases and commit absorption.
// Optional same-cycle commit-to-read forwarding is enabled by defining REG_COMMIT_BYPASS_EN.
module reg_file #(
    parameter int REG_NUM  = 32,
    parameter int XLEN     = 32,
    parameter int ROB_ID_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                rollback_signal,
    input  logic [4:0]          rs1_from_dsp,
    input  logic [4:0]          rs2_from_dsp,
    output logic [XLEN-1:0]     Vi_2dsp,
    output logic [XLEN-1:0]     Vj_2dsp,
    output logic [ROB_ID_W-1:0] Qi_2dsp,
    output logic [ROB_ID_W-1:0] Qj_2dsp,
    input  logic                rename_ena_from_dsp,
    input  logic [4:0]          rd_from_dsp,
    input  logic [ROB_ID_W-1:0] rename_id_from_dsp,
    input  logic                res_rdy_from_rob,
    input  logic [4:0]          regidx_from_rob,
    input  logic [XLEN-1:0]     res_from_rob,
    input  logic [ROB_ID_W-1:0] alias_from_rob
);

    logic [XLEN-1:0]     r_val   [REG_NUM];
    logic [ROB_ID_W-1:0] r_alias [REG_NUM];

    logic w_commit;
    logic w_rename;
    logic w_alias_match;

    assign w_commit      = res_rdy_from_rob && (regidx_from_rob != 5'd0);
    assign w_rename      = rename_ena_from_dsp && (rd_from_dsp != 5'd0);
    assign w_alias_match = (r_alias[regidx_from_rob] == alias_from_rob);

    // Rename is ordered after the alias clear so it wins on a same-register collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < REG_NUM; i++) begin
                r_val[i]   <= '0;
                r_alias[i] <= '0;
            end
        end else if (rollback_signal) begin
            for (int unsigned i = 0; i < REG_NUM; i++) begin
                r_alias[i] <= '0;
            end
            if (w_commit) begin
                r_val[regidx_from_rob] <= res_from_rob;
            end
        end else if (rdy) begin
            if (w_commit) begin
                r_val[regidx_from_rob] <= res_from_rob;
                if (w_alias_match) begin
                    r_alias[regidx_from_rob] <= '0;
                end
            end
            if (w_rename) begin
                r_alias[rd_from_dsp] <= rename_id_from_dsp;
            end
        end
    end

`ifdef REG_COMMIT_BYPASS_EN
    logic w_hit1;
    logic w_hit2;

    assign w_hit1 = w_commit && (rs1_from_dsp == regidx_from_rob) && w_alias_match;
    assign w_hit2 = w_commit && (rs2_from_dsp == regidx_from_rob) && w_alias_match;

    always_comb begin
        Qi_2dsp = '0;
        Vi_2dsp = '0;
        Qj_2dsp = '0;
        Vj_2dsp = '0;
        if (rs1_from_dsp != 5'd0) begin
            Qi_2dsp = w_hit1 ? '0 : r_alias[rs1_from_dsp];
            Vi_2dsp = w_hit1 ? res_from_rob : r_val[rs1_from_dsp];
        end
        if (rs2_from_dsp != 5'd0) begin
            Qj_2dsp = w_hit2 ? '0 : r_alias[rs2_from_dsp];
            Vj_2dsp = w_hit2 ? res_from_rob : r_val[rs2_from_dsp];
        end
    end
`else
    always_comb begin
        Qi_2dsp = '0;
        Vi_2dsp = '0;
        Qj_2dsp = '0;
        Vj_2dsp = '0;
        if (rs1_from_dsp != 5'd0) begin
            Qi_2dsp = r_alias[rs1_from_dsp];
            Vi_2dsp = r_val[rs1_from_dsp];
        end
        if (rs2_from_dsp != 5'd0) begin
            Qj_2dsp = r_alias[rs2_from_dsp];
            Vj_2dsp = r_val[rs2_from_dsp];
        end
    end
`endif

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: stimulus queues expected read-port values per cycle,
// a negedge monitor pops and compares them.
module tb_reg_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        rollback_signal;
    logic [4:0]  rs1_from_dsp;
    logic [4:0]  rs2_from_dsp;
    logic [31:0] Vi_2dsp;
    logic [31:0] Vj_2dsp;
    logic [3:0]  Qi_2dsp;
    logic [3:0]  Qj_2dsp;
    logic        rename_ena_from_dsp;
    logic [4:0]  rd_from_dsp;
    logic [3:0]  rename_id_from_dsp;
    logic        res_rdy_from_rob;
    logic [4:0]  regidx_from_rob;
    logic [31:0] res_from_rob;
    logic [3:0]  alias_from_rob;

    reg_file #(.REG_NUM(32), .XLEN(32), .ROB_ID_W(4)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .rdy                 (rdy),
        .rollback_signal     (rollback_signal),
        .rs1_from_dsp        (rs1_from_dsp),
        .rs2_from_dsp        (rs2_from_dsp),
        .Vi_2dsp             (Vi_2dsp),
        .Vj_2dsp             (Vj_2dsp),
        .Qi_2dsp             (Qi_2dsp),
        .Qj_2dsp             (Qj_2dsp),
        .rename_ena_from_dsp (rename_ena_from_dsp),
        .rd_from_dsp         (rd_from_dsp),
        .rename_id_from_dsp  (rename_id_from_dsp),
        .res_rdy_from_rob    (res_rdy_from_rob),
        .regidx_from_rob     (regidx_from_rob),
        .res_from_rob        (res_from_rob),
        .alias_from_rob      (alias_from_rob)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned cyc;
        string       name;
        logic [3:0]  qi;
        logic [31:0] vi;
        logic [3:0]  qj;
        logic [31:0] vj;
    } exp_t;

    exp_t        sb[$];
    int unsigned cycle = 0;
    int          n_vec = 0;
    int          n_err = 0;

    always @(posedge clk) cycle <= cycle + 1;

    // Monitor: compares every expectation tagged with the current cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cycle) begin
            exp_t e;
            e = sb.pop_front();
            n_vec++;
            if (e.cyc != cycle) begin
                n_err++;
                $display("FAIL %s: stale expectation from cycle %0d, now %0d", e.name, e.cyc, cycle);
            end else if (Qi_2dsp !== e.qi || Vi_2dsp !== e.vi || Qj_2dsp !== e.qj || Vj_2dsp !== e.vj) begin
                n_err++;
                $display("FAIL %s: got Qi=%0d Vi=%h Qj=%0d Vj=%h, want Qi=%0d Vi=%h Qj=%0d Vj=%h",
                         e.name, Qi_2dsp, Vi_2dsp, Qj_2dsp, Vj_2dsp, e.qi, e.vi, e.qj, e.vj);
            end
        end
    end

    task automatic push_exp(input string n, input logic [3:0] qi, input logic [31:0] vi,
                            input logic [3:0] qj, input logic [31:0] vj);
        exp_t e;
        e.cyc  = cycle;
        e.name = n;
        e.qi   = qi;
        e.vi   = vi;
        e.qj   = qj;
        e.vj   = vj;
        sb.push_back(e);
    endtask

    task automatic query(input logic [4:0] a, input logic [4:0] b);
        rs1_from_dsp = a;
        rs2_from_dsp = b;
    endtask

    task automatic ren(input logic [4:0] rd, input logic [3:0] id);
        rename_ena_from_dsp = 1'b1;
        rd_from_dsp         = rd;
        rename_id_from_dsp  = id;
    endtask

    task automatic cmt(input logic [4:0] idx, input logic [31:0] v, input logic [3:0] al);
        res_rdy_from_rob = 1'b1;
        regidx_from_rob  = idx;
        res_from_rob     = v;
        alias_from_rob   = al;
    endtask

    // Advance one clock; pulse inputs are single-cycle and cleared after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        rename_ena_from_dsp = 1'b0;
        res_rdy_from_rob    = 1'b0;
        rollback_signal     = 1'b0;
        rd_from_dsp         = 5'd0;
        rename_id_from_dsp  = 4'd0;
        regidx_from_rob     = 5'd0;
        res_from_rob        = 32'd0;
        alias_from_rob      = 4'd0;
    endtask

    initial begin
        rst = 1'b1;
        rdy = 1'b1;
        rollback_signal = 1'b0;
        rename_ena_from_dsp = 1'b0;
        res_rdy_from_rob = 1'b0;
        rd_from_dsp = '0;
        rename_id_from_dsp = '0;
        regidx_from_rob = '0;
        res_from_rob = '0;
        alias_from_rob = '0;
        query(5'd0, 5'd0);
        tick();
        tick();
        rst = 1'b0;

        query(5'd5, 5'd0);
        push_exp("reset_state", 4'd0, 32'd0, 4'd0, 32'd0);
        tick();

        ren(5'd5, 4'd3);
        query(5'd5, 5'd0);
        push_exp("rename_not_yet_visible", 4'd0, 32'd0, 4'd0, 32'd0);
        tick();
        query(5'd5, 5'd5);
        push_exp("rename_x5_a3", 4'd3, 32'd0, 4'd3, 32'd0);
        tick();

        cmt(5'd5, 32'hDEADBEEF, 4'd3);
        query(5'd0, 5'd0);
        tick();
        query(5'd5, 5'd5);
        push_exp("commit_x5", 4'd0, 32'hDEADBEEF, 4'd0, 32'hDEADBEEF);
        tick();

        ren(5'd7, 4'd2);
        tick();
        ren(5'd7, 4'd4);
        tick();
        query(5'd7, 5'd0);
        push_exp("rename_x7_a4", 4'd4, 32'd0, 4'd0, 32'd0);
        cmt(5'd7, 32'h11, 4'd2);
        tick();
        query(5'd7, 5'd5);
        push_exp("stale_commit_keeps_alias", 4'd4, 32'h11, 4'd0, 32'hDEADBEEF);
        tick();

        cmt(5'd9, 32'h22, 4'd1);
        ren(5'd9, 4'd6);
        query(5'd0, 5'd0);
        tick();
        query(5'd9, 5'd0);
        push_exp("commit_rename_same_reg", 4'd6, 32'h22, 4'd0, 32'd0);
        tick();

        for (int i = 1; i <= 4; i++) begin
            ren(5'(i), 4'(i));
            tick();
        end
        query(5'd1, 5'd4);
        push_exp("renamed_x1_x4", 4'd1, 32'd0, 4'd4, 32'd0);
        rollback_signal = 1'b1;
        ren(5'd8, 4'd5);
        cmt(5'd6, 32'h66, 4'd7);
        tick();
        query(5'd2, 5'd3);
        push_exp("rollback_x2_x3", 4'd0, 32'd0, 4'd0, 32'd0);
        tick();
        query(5'd8, 5'd6);
        push_exp("rollback_drops_rename_keeps_commit", 4'd0, 32'd0, 4'd0, 32'h66);
        tick();
        query(5'd7, 5'd9);
        push_exp("rollback_values_kept", 4'd0, 32'h11, 4'd0, 32'h22);
        tick();

        rdy = 1'b0;
        ren(5'd11, 4'd5);
        cmt(5'd12, 32'h55, 4'd0);
        tick();
        rdy = 1'b1;
        query(5'd11, 5'd12);
        push_exp("rdy_low_inputs_lost", 4'd0, 32'd0, 4'd0, 32'd0);
        tick();

        ren(5'd10, 4'd2);
        tick();
        cmt(5'd10, 32'h33, 4'd2);
        query(5'd10, 5'd10);
`ifdef REG_COMMIT_BYPASS_EN
        push_exp("commit_same_cycle_x10", 4'd0, 32'h33, 4'd0, 32'h33);
`else
        push_exp("commit_same_cycle_x10", 4'd2, 32'd0, 4'd2, 32'd0);
`endif
        tick();
        query(5'd10, 5'd0);
        push_exp("commit_next_cycle_x10", 4'd0, 32'h33, 4'd0, 32'd0);
        tick();

        ren(5'd0, 4'd5);
        cmt(5'd0, 32'h99, 4'd0);
        query(5'd0, 5'd0);
        push_exp("x0_write_cycle", 4'd0, 32'd0, 4'd0, 32'd0);
        tick();
        query(5'd0, 5'd0);
        push_exp("x0_stays_zero", 4'd0, 32'd0, 4'd0, 32'd0);
        tick();

        ren(5'd13, 4'd9);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        query(5'd5, 5'd13);
        push_exp("mid_reset_clears", 4'd0, 32'd0, 4'd0, 32'd0);
        tick();

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            n_err += sb.size();
            $display("FAIL drain: %0d expectations never checked, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
